// File: rtl/cache_refill_engine.sv
// Miss-handling engine: optional dirty-victim write-back, beat-wise line refill, single-pulse data-memory write.
// Handshakes: req accepted when req_valid & req_ready; a memory beat transfers when mem_req_valid & mem_req_ready, with request fields held until then.
module cache_refill_engine #(
  parameter int AINDEX_WIDTH    = 3,
  parameter int CH_NUM_WIDTH    = 2,
  parameter int CASH_MEM_WIDTH  = 128,
  parameter int BEAT_W          = 2,
  parameter int LINE_ADDR_WIDTH = 30
) (
  input  logic                              clk,
  input  logic                              nReset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [AINDEX_WIDTH-1:0]           req_index,
  input  logic [CH_NUM_WIDTH-1:0]           req_chan,
  input  logic [LINE_ADDR_WIDTH-1:0]        req_line_addr,
  input  logic                              req_dirty,
  input  logic [LINE_ADDR_WIDTH-1:0]        req_victim_addr,
  output logic                              done,
  output logic [AINDEX_WIDTH-1:0]           dm_index,
  output logic [CH_NUM_WIDTH-1:0]           dm_chan,
  output logic                              dm_wr,
  output logic [CASH_MEM_WIDTH-1:0]         dm_data_in,
  input  logic [CASH_MEM_WIDTH-1:0]         dm_data_out,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_we,
  output logic [LINE_ADDR_WIDTH+BEAT_W-1:0] mem_addr,
  output logic [(CASH_MEM_WIDTH>>BEAT_W)-1:0] mem_wdata,
  input  logic                              mem_rvalid,
  input  logic [(CASH_MEM_WIDTH>>BEAT_W)-1:0] mem_rdata,
  output logic [2:0]                        dbg_state_o
);
  localparam int BUS_WIDTH = CASH_MEM_WIDTH >> BEAT_W;
  localparam int BEATS     = 1 << BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_CAP  = 3'd1,
    WB_SEND = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    FILL    = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [AINDEX_WIDTH-1:0]     index_q, index_d;
  logic [CH_NUM_WIDTH-1:0]     chan_q, chan_d;
  logic [LINE_ADDR_WIDTH-1:0]  line_addr_q, line_addr_d;
  logic [LINE_ADDR_WIDTH-1:0]  victim_addr_q, victim_addr_d;
  logic [CASH_MEM_WIDTH-1:0]   line_buf_q, line_buf_d;
  logic [CASH_MEM_WIDTH-1:0]   victim_buf_q, victim_buf_d;
  logic                        done_q, done_d;
  logic                        dm_wr_q, dm_wr_d;
  logic [CASH_MEM_WIDTH-1:0]   dm_data_in_q, dm_data_in_d;
  logic                        mem_req_valid_q, mem_req_valid_d;
  logic                        mem_req_we_q, mem_req_we_d;
  logic [LINE_ADDR_WIDTH+BEAT_W-1:0] mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0]        mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      index_q         <= '0;
      chan_q          <= '0;
      line_addr_q     <= '0;
      victim_addr_q   <= '0;
      line_buf_q      <= '0;
      victim_buf_q    <= '0;
      done_q          <= 1'b0;
      dm_wr_q         <= 1'b0;
      dm_data_in_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      index_q         <= index_d;
      chan_q          <= chan_d;
      line_addr_q     <= line_addr_d;
      victim_addr_q   <= victim_addr_d;
      line_buf_q      <= line_buf_d;
      victim_buf_q    <= victim_buf_d;
      done_q          <= done_d;
      dm_wr_q         <= dm_wr_d;
      dm_data_in_q    <= dm_data_in_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    index_d       = index_q;
    chan_d        = chan_q;
    line_addr_d   = line_addr_q;
    victim_addr_d = victim_addr_q;
    line_buf_d    = line_buf_q;
    victim_buf_d  = victim_buf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          index_d       = req_index;
          chan_d        = req_chan;
          line_addr_d   = req_line_addr;
          victim_addr_d = req_victim_addr;
          beat_d        = '0;
          state_d       = req_dirty ? WB_CAP : RD_REQ;
        end
      end
      WB_CAP: begin
        victim_buf_d = dm_data_out;
        state_d      = WB_SEND;
      end
      WB_SEND: begin
        if (mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          line_buf_d[beat_q*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
          beat_d  = beat_q + 1'b1;
          state_d = (beat_q == LAST_BEAT) ? FILL : RD_REQ;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    mem_req_valid_d = (state_d == WB_SEND) || (state_d == RD_REQ);
    mem_req_we_d    = (state_d == WB_SEND);
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    if (state_d == WB_SEND) begin
      mem_addr_d  = {victim_addr_d, beat_d};
      mem_wdata_d = victim_buf_d[beat_d*BUS_WIDTH +: BUS_WIDTH];
    end else if (state_d == RD_REQ) begin
      mem_addr_d  = {line_addr_d, beat_d};
    end
    dm_wr_d      = (state_d == FILL);
    done_d       = (state_d == FILL);
    dm_data_in_d = (state_d == FILL) ? line_buf_d : dm_data_in_q;
  end

  assign req_ready     = (state_q == IDLE);
  assign done          = done_q;
  assign dm_index      = index_q;
  assign dm_chan       = chan_q;
  assign dm_wr         = dm_wr_q;
  assign dm_data_in    = dm_data_in_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign dbg_state_o   = state_q;
endmodule
